// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
//
// Multicycle control unit for an RV32I core built around a shared-memory
// datapath (PC, IR, ALUOut, register file, one memory port). Each opcode walks
// its own state sequence. Memory accesses use a request/ready handshake and an
// optional wait-cycle timeout. Illegal instructions and bus timeouts stop the
// core in a sticky TRAP state. ALU function decoding is done outside this
// block; only the 2-bit alu_op class is produced here.
//
// Parameters
//   CNT_W    width of the retired-instruction counter
//   TIMEOUT  memory wait cycles allowed before a bus trap (0 = never trap)
//   TMO_W    width of the wait counter (TIMEOUT < 2**TMO_W)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   instr                 IR contents (opcode [6:0], funct3 [14:12])
//   zero/negative/
//   carry/overflow        ALU flags; carry is the carry-out of A+~B+1
//   mem_ready             memory completes the current request this cycle
//   halt                  stall request, honoured in FETCH only
//   mem_req, mem_write    memory request / store strobe
//   adr_src               memory address: 0 = PC, 1 = ALUOut
//   ir_write, pc_write,
//   reg_write             register enables
//   result_src            00 = ALUOut, 01 = read data, 10 = ALU result
//   alu_src_a             00 = PC, 01 = oldPC, 10 = rd1
//   alu_src_b             00 = rd2, 01 = immext, 10 = constant 4
//   alu_op                00 = ADD, 01 = SUB, 10 = by funct, 11 = PASS B
//   retire, instret       retire pulse and retired-instruction count
//   trap, trap_cause      core stopped; 01 = illegal, 10 = bus timeout
//   state                 current state encoding (debug)
// -----------------------------------------------------------------------------
module control_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             negative,
  input  logic             carry,
  input  logic             overflow,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_JALR      = 4'd11,
    ST_LINK      = 4'd12,
    ST_UPPER     = 4'd13,
    ST_TRAP      = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLDPC    = 2'b01;
  localparam logic [1:0] A_RD1      = 2'b10;
  localparam logic [1:0] B_RD2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_FUNCT   = 2'b10;
  localparam logic [1:0] OP_PASS    = 2'b11;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_BUS  = 2'b10;

  localparam logic             TMO_EN    = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_busy;
  logic       mem_wait;
  logic       tmo_hit;
  logic       br_taken;
  state_e     dec_next;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  // A FETCH request is withdrawn while halt is high, so halted cycles never
  // count as memory wait cycles.
  assign mem_busy = (state_q == ST_FETCH) ? !halt
                  : ((state_q == ST_MEM_READ) || (state_q == ST_MEM_WRITE));
  assign mem_wait = mem_busy && !mem_ready;
  assign tmo_hit  = TMO_EN && mem_wait && (wait_cnt_q == TMO_LIMIT);

  // Flags come from rd1 - rd2: signed less-than is N^V, unsigned less-than is
  // the absence of a carry out of A+~B+1.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = negative ^ overflow;
      3'b101:  br_taken = !(negative ^ overflow);
      3'b110:  br_taken = !carry;
      3'b111:  br_taken = carry;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    dec_next = ST_TRAP;
    case (opcode)
      OP_LOAD, OP_STORE:  dec_next = ST_MEM_ADR;
      OP_R:               dec_next = ST_EXEC_R;
      OP_I_ALU:           dec_next = ST_EXEC_I;
      OP_BRANCH:          dec_next = (funct3[2:1] == 2'b01) ? ST_TRAP : ST_BRANCH;
      OP_JAL:             dec_next = ST_JAL;
      OP_JALR:            dec_next = (funct3 == 3'b000) ? ST_JALR : ST_TRAP;
      OP_LUI, OP_AUIPC:   dec_next = ST_UPPER;
      default:            dec_next = ST_TRAP;
    endcase
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    mem_req      = mem_busy;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = A_PC;
    alu_src_b    = B_RD2;
    alu_op       = OP_ADD;
    retire       = 1'b0;
    trap         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        if (mem_ready && !halt) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (tmo_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_BUS;
        end
      end
      ST_DECODE: begin
        // Branch/JAL target is computed here and parked in ALUOut.
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        state_d   = dec_next;
        if (dec_next == ST_TRAP) trap_cause_d = CAUSE_ILL;
      end
      ST_MEM_ADR: begin
        alu_src_a = A_RD1;
        alu_src_b = B_IMM;
        state_d   = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (tmo_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_BUS;
        end
      end
      ST_MEM_WB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (tmo_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = CAUSE_BUS;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = A_RD1;
        alu_src_b = B_RD2;
        alu_op    = OP_FUNCT;
        state_d   = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a = A_RD1;
        alu_src_b = B_IMM;
        alu_op    = OP_FUNCT;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = A_RD1;
        alu_src_b = B_RD2;
        alu_op    = OP_SUB;
        pc_write  = br_taken;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JAL: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4,
        // which ALU_WB then writes to rd.
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
        state_d   = ST_ALU_WB;
      end
      ST_JALR: begin
        alu_src_a  = A_RD1;
        alu_src_b  = B_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_d    = ST_LINK;
      end
      ST_LINK: begin
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_UPPER: begin
        alu_src_b  = B_IMM;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
        if (opcode == OP_LUI) alu_op    = OP_PASS;
        else                  alu_src_a = A_OLDPC;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // The state register already sits in FETCH during reset; suppress the
    // enables that FETCH would otherwise raise.
    if (!rst_n) begin
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) &&
        ((state_d == ST_FETCH) || (state_d == ST_MEM_READ) || (state_d == ST_MEM_WRITE)))
      wait_cnt_d = '0;
    else if (mem_wait)
      wait_cnt_d = wait_cnt_q + TMO_W'(1);

    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      trap_cause_q <= CAUSE_NONE;
      wait_cnt_q   <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      wait_cnt_q   <= wait_cnt_d;
      instret_q    <= instret_d;
    end
  end

  assign instret    = instret_q;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;

endmodule
